// File: rtl/sseg_pkg.sv
// sseg_pkg: shared glyph table, scan FSM states and anode index helper for the 7-segment path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package sseg_pkg;

   localparam int SSEG_W = 7;

   // Segment codes gfedcba, active-low (0 = lit), indexed by hex value.
   localparam logic [SSEG_W-1:0] SSEG_CODES [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HELD
   } scan_state_t;

   // Index of the lowest zero bit; callers pad unused upper bits with ones.
   function automatic logic [4:0] onehot_low_idx(input logic [31:0] an_bits);
      logic [4:0] idx;
      idx = '0;
      for (int b = 31; b >= 0; b--) begin
         if (!an_bits[b]) idx = 5'(b);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sseg2hex.sv
// sseg2hex: reverse glyph lookup, segment pattern -> {hit, hex}, from the shared code table.
// Latency: combinational. Backpressure: none.
// Ports: sseg (gfedcba, active-low) in; hit (pattern is a hex glyph) and hex (value) out.
module sseg2hex
   import sseg_pkg::*;
(
   input  logic [SSEG_W-1:0] sseg,
   output logic              hit,
   output logic [3:0]        hex
);

   always_comb begin
      hit = 1'b0;
      hex = '0;
      for (int v = 0; v < 16; v++) begin
         if (sseg == SSEG_CODES[v]) begin
            hit = 1'b1;
            hex = 4'(v);
         end
      end
   end

endmodule

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: samples a multiplexed 7-segment bus and rebuilds each digit's hex value.
// Latency: capture_stb SYNC_STAGES+STABLE_CYCLES cycles after a new an/sseg is first sampled.
// Backpressure: none; the display bus cannot be stalled, unstable patterns are simply ignored.
// Ports: clk, rst (sync, active-high); an/sseg bus in; hex_flat, digit_valid, digit_bad,
//        capture_stb, capture_idx out.
module sseg_scan_decoder
   import sseg_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_DIGITS-1:0]         an,
   input  logic [6:0]                  sseg,
   output logic [4*N_DIGITS-1:0]       hex_flat,
   output logic [N_DIGITS-1:0]         digit_valid,
   output logic [N_DIGITS-1:0]         digit_bad,
   output logic                        capture_stb,
   output logic [$clog2(N_DIGITS)-1:0] capture_idx
);

   localparam int S_W   = N_DIGITS + SSEG_W;
   localparam int IDX_W = $clog2(N_DIGITS);
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   logic [S_W-1:0]      sync_q [SYNC_STAGES];
   logic [S_W-1:0]      samp;
   logic [S_W-1:0]      prev_q;
   logic [N_DIGITS-1:0] an_s;
   logic [N_DIGITS-1:0] an_low;
   logic [SSEG_W-1:0]   seg_s;
   logic                onehot;
   logic                changed;
   logic                cap_now;
   logic                dec_hit;
   logic [3:0]          dec_hex;
   logic [IDX_W-1:0]    cap_idx;
   scan_state_t         state;
   logic [CNT_W-1:0]    settle_cnt;
   logic [TO_W-1:0]     to_cnt [N_DIGITS];

   // All-ones reset value reads as a blank display with no anode active.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '1;
      end else begin
         sync_q[0] <= {an, sseg};
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign samp    = sync_q[SYNC_STAGES-1];
   assign an_s    = samp[S_W-1:SSEG_W];
   assign seg_s   = samp[SSEG_W-1:0];
   assign an_low  = ~an_s;
   // Exactly one anode low: non-zero and a power of two.
   assign onehot  = (an_low != '0) && ((an_low & (an_low - N_DIGITS'(1))) == '0);
   assign changed = (samp != prev_q);
   assign cap_now = (state == SETTLE) && !changed && (settle_cnt == CNT_DONE);
   assign cap_idx = IDX_W'(onehot_low_idx({{(32-N_DIGITS){1'b1}}, an_s}));

   sseg2hex u_dec (
      .sseg (seg_s),
      .hit  (dec_hit),
      .hex  (dec_hex)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         settle_cnt  <= '0;
         prev_q      <= '1;
         hex_flat    <= '0;
         digit_valid <= '0;
         digit_bad   <= '0;
         capture_stb <= 1'b0;
         capture_idx <= '0;
         for (int i = 0; i < N_DIGITS; i++) to_cnt[i] <= '0;
      end else begin
         prev_q      <= samp;
         capture_stb <= cap_now;
         if (cap_now) capture_idx <= cap_idx;

         case (state)
            IDLE: begin
               if (onehot) begin
                  state      <= SETTLE;
                  settle_cnt <= CNT_W'(1);
               end
            end
            default: begin
               // SETTLE and HELD react identically to a new sample.
               if (changed) begin
                  state      <= onehot ? SETTLE : IDLE;
                  settle_cnt <= onehot ? CNT_W'(1) : '0;
               end else if (state == SETTLE) begin
                  if (cap_now) begin
                     state      <= HELD;
                     settle_cnt <= '0;
                  end else begin
                     settle_cnt <= settle_cnt + CNT_W'(1);
                  end
               end
            end
         endcase

         // Capture takes priority over the timeout on the same digit.
         for (int i = 0; i < N_DIGITS; i++) begin
            if (cap_now && (cap_idx == IDX_W'(i))) begin
               to_cnt[i]      <= '0;
               digit_valid[i] <= dec_hit;
               digit_bad[i]   <= !dec_hit;
               if (dec_hit) hex_flat[4*i +: 4] <= dec_hex;
            end else if (to_cnt[i] != TO_MAX) begin
               to_cnt[i] <= to_cnt[i] + TO_W'(1);
               if (to_cnt[i] == TO_LAST) digit_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb_sseg_scan_decoder: directed scenarios plus random bus traffic against a run-length reference model.
// Ports of the DUT are all driven/observed here; timeout shortened to 64 cycles.
module tb_sseg_scan_decoder;

   localparam int N      = 4;
   localparam int SYNC   = 2;
   localparam int STABLE = 16;
   localparam int TMO    = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  an;
   logic [6:0]  sseg;
   logic [15:0] hex_flat;
   logic [3:0]  digit_valid;
   logic [3:0]  digit_bad;
   logic        capture_stb;
   logic [1:0]  capture_idx;

   sseg_scan_decoder #(
      .N_DIGITS       (N),
      .SYNC_STAGES    (SYNC),
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .sseg        (sseg),
      .hex_flat    (hex_flat),
      .digit_valid (digit_valid),
      .digit_bad   (digit_bad),
      .capture_stb (capture_stb),
      .capture_idx (capture_idx)
   );

   always #5 clk = ~clk;

   // Common-anode hex glyphs, gfedcba, 0 = lit.
   logic [6:0] glyph [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int low_index(input logic [3:0] a);
      for (int b = 0; b < 4; b++) if (a[b] == 1'b0) return b;
      return 0;
   endfunction

   // Hex value of a glyph, -1 when the pattern is not a hex digit.
   function automatic int glyph_value(input logic [6:0] s);
      for (int v = 0; v < 16; v++) if (glyph[v] == s) return v;
      return -1;
   endfunction

   // Reference model: a pattern captures once its run of identical raw samples
   // reaches STABLE+1 with exactly one anode low; the capture appears SYNC
   // cycles later. A reset discards the input run and anything still pending.
   logic [10:0] m_last;
   int          m_rl;
   int          due_q[$];
   logic [3:0]  an_q[$];
   logic [6:0]  seg_q[$];
   logic [15:0] m_hex;
   logic [3:0]  m_valid, m_bad;
   logic        m_stb;
   int          m_idx, m_d, m_gv;
   int          cap_cyc [4];

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_last = '1; m_rl = 0;
         due_q.delete(); an_q.delete(); seg_q.delete();
         m_hex = '0; m_valid = '0; m_bad = '0; m_stb = 1'b0; m_idx = 0;
      end else begin
         if ({an, sseg} == m_last) m_rl++;
         else begin
            m_rl   = 1;
            m_last = {an, sseg};
         end
         if (m_rl == STABLE + 1 && $countones(~an) == 1) begin
            due_q.push_back(cyc + SYNC);
            an_q.push_back(an);
            seg_q.push_back(sseg);
         end
         m_stb = 1'b0;
         for (int i = 0; i < 4; i++)
            if (m_valid[i] && (cyc - cap_cyc[i] >= TMO)) m_valid[i] = 1'b0;
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            m_d  = low_index(an_q[0]);
            m_gv = glyph_value(seg_q[0]);
            void'(due_q.pop_front()); void'(an_q.pop_front()); void'(seg_q.pop_front());
            m_stb = 1'b1;
            m_idx = m_d;
            cap_cyc[m_d] = cyc;
            if (m_gv >= 0) begin
               m_hex[4*m_d +: 4] = 4'(m_gv);
               m_valid[m_d] = 1'b1;
               m_bad[m_d]   = 1'b0;
            end else begin
               m_valid[m_d] = 1'b0;
               m_bad[m_d]   = 1'b1;
            end
         end
      end
   end

   bit   chk_on = 1'b0;
   int   stb_count = 0, last_stb_cyc = 0, last_stb_idx = 0, v3_fall_cyc = 0;
   logic v3_prev = 1'b0;

   always @(negedge clk) begin
      if (chk_on) begin
         check_eq("capture_stb", 32'(capture_stb), 32'(m_stb));
         if (m_stb) check_eq("capture_idx", 32'(capture_idx), m_idx);
         check_eq("hex_flat", 32'(hex_flat), 32'(m_hex));
         check_eq("digit_valid", 32'(digit_valid), 32'(m_valid));
         check_eq("digit_bad", 32'(digit_bad), 32'(m_bad));
         if (capture_stb === 1'b1) begin
            stb_count++;
            last_stb_cyc = cyc;
            last_stb_idx = int'(capture_idx);
         end
         if (v3_prev && !digit_valid[3]) v3_fall_cyc = cyc;
         v3_prev = digit_valid[3];
      end
   end

   task automatic apply(input logic [3:0] a, input logic [6:0] s, input int n);
      an   = a;
      sseg = s;
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      int c0, n0;
      rst = 1'b1; an = '1; sseg = '1;
      repeat (3) @(negedge clk);
      #1;
      chk_on = 1'b1;
      check_eq("reset_hex", 32'(hex_flat), 0);
      check_eq("reset_valid", 32'(digit_valid), 0);
      check_eq("reset_bad", 32'(digit_bad), 0);
      check_eq("reset_stb", 32'(capture_stb), 0);
      check_eq("reset_idx", 32'(capture_idx), 0);
      rst = 1'b0;

      // Single digit 0 showing "2".
      c0 = cyc; n0 = stb_count;
      apply(4'b1110, 7'b0100100, 30);
      check_eq("t1_strobes", stb_count - n0, 1);
      check_eq("t1_latency", last_stb_cyc - (c0 + 1), SYNC + STABLE);
      check_eq("t1_idx", last_stb_idx, 0);
      check_eq("t1_hex", 32'(hex_flat[3:0]), 2);
      check_eq("t1_valid", 32'(digit_valid), 32'b0001);
      check_eq("t1_bad", 32'(digit_bad), 0);

      // Full scan A,5,0,F.
      n0 = stb_count;
      apply(4'b1110, glyph[10], 20);
      apply(4'b1101, glyph[5], 20);
      apply(4'b1011, glyph[0], 20);
      apply(4'b0111, glyph[15], 20);
      check_eq("t2_hex", 32'(hex_flat), 32'hF05A);
      check_eq("t2_valid", 32'(digit_valid), 32'hF);
      check_eq("t2_strobes", stb_count - n0, 4);

      // Blank on digit 1 is not a hex glyph.
      apply(4'b1101, 7'b1111111, 24);
      check_eq("t3_bad1", 32'(digit_bad[1]), 1);
      check_eq("t3_valid1", 32'(digit_valid[1]), 0);
      check_eq("t3_hex1", 32'(hex_flat[7:4]), 5);

      // Short glitches and two anodes low never capture.
      n0 = stb_count;
      for (int k = 0; k < 6; k++) apply(4'b1011, (k % 2) ? glyph[1] : glyph[8], 10);
      apply(4'b1001, glyph[4], 40);
      check_eq("t4_strobes", stb_count - n0, 0);

      // Timeout of digit 3.
      apply(4'b0111, glyph[7], 20);
      apply(4'b1111, 7'b1111111, 70);
      check_eq("t5_idx", last_stb_idx, 3);
      check_eq("t5_timeout", v3_fall_cyc - last_stb_cyc, TMO);
      check_eq("t5_valid3", 32'(digit_valid[3]), 0);
      check_eq("t5_hex3", 32'(hex_flat[15:12]), 7);

      // Random traffic, mostly legal scans with occasional resets.
      for (int it = 0; it < 200; it++) begin
         int r;
         logic [3:0] a;
         logic [6:0] s;
         r = $urandom_range(0, 9);
         if (r < 7)      a = ~(4'b0001 << $urandom_range(0, 3));
         else if (r < 8) a = 4'hF;
         else            a = 4'($urandom);
         s = ($urandom_range(0, 3) != 0) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            #1;
            rst = 1'b0;
         end
         apply(a, s, $urandom_range(1, 30));
      end

      // Make sure there is state to clear, then reset mid-SETTLE (counter at 10).
      apply(4'b1110, glyph[9], 20);
      apply(4'b1011, glyph[3], 12);
      rst = 1'b1; an = '1; sseg = '1;
      @(negedge clk);
      #1;
      rst = 1'b0;
      check_eq("t6_hex", 32'(hex_flat), 0);
      check_eq("t6_valid", 32'(digit_valid), 0);
      check_eq("t6_bad", 32'(digit_bad), 0);
      check_eq("t6_stb", 32'(capture_stb), 0);
      check_eq("t6_idx", 32'(capture_idx), 0);
      n0 = stb_count;
      apply(4'b1111, 7'b1111111, 40);
      check_eq("t6_no_stale", stb_count - n0, 0);

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
